// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word, write-mask and memory responder state types
package lc3b_types;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0] lc3b_mem_wmask;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_responder_state_t;
endpackage

// File: rtl/mem_responder_array.sv
// mem_responder_array: 2^ADDR_BITS x 16 storage with per-lane write enable and registered read port
import lc3b_types::*;
module mem_responder_array #(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic                 re_i,
  input  logic                 zero_i,
  input  lc3b_mem_wmask        be_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  lc3b_word             wdata_i,
  output lc3b_word             rdata_o
);
  lc3b_word mem_q [2**ADDR_BITS];
  lc3b_word rdata_q;
  lc3b_word merged;
  assign merged = {be_i[1] ? wdata_i[15:8] : mem_q[addr_i][15:8],
                   be_i[0] ? wdata_i[7:0]  : mem_q[addr_i][7:0]};
  assign rdata_o = rdata_q;
  // store the lane-merged word; storage is never cleared by reset
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= merged;
  end
  // read port returns the post-write word when a write commits in the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= zero_i ? '0 : we_i ? merged : mem_q[addr_i];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed data memory answering the pipeline handshake after WAIT_STATES cycles
// Optional misaligned-access check: define MEM_RESPONDER_ALIGN_CHECK_EN
import lc3b_types::*;
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  lc3b_word      mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_wdata,
  output lc3b_word      mem_rdata,
  output logic          mem_resp,
  output logic          busy
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  ,
  output logic          mem_error
`endif
);
  mem_responder_state_t state_q;
  logic [3:0]         cnt_q;
  logic [ADDR_BITS:0] addr_q;
  lc3b_word           wdata_q;
  lc3b_mem_wmask      be_q;
  logic               wr_q, rd_q, resp_q, busy_q;
  logic               req, idle, commit, mis, c_wr, c_rd;
  logic [ADDR_BITS:0] c_addr;
  lc3b_word           c_wdata;
  lc3b_mem_wmask      c_be;
  logic               unused_ok;
  // with zero wait states the commit happens on the acceptance edge, so use live inputs there
  assign req     = mem_read | mem_write;
  assign idle    = state_q == IDLE;
  assign commit  = (idle && req && WAIT_STATES == 0) || (state_q == WAIT && cnt_q == 4'd1);
  assign c_addr  = idle ? mem_address[ADDR_BITS:0] : addr_q;
  assign c_wdata = idle ? mem_wdata : wdata_q;
  assign c_be    = idle ? mem_byte_enable : be_q;
  assign c_wr    = idle ? mem_write : wr_q;
  assign c_rd    = idle ? mem_read : rd_q;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic err_q;
  assign mis       = c_be == 2'b11 && c_addr[0];
  assign mem_error = err_q;
`else
  assign mis = 1'b0;
`endif
  assign mem_resp  = resp_q;
  assign busy      = busy_q;
  assign unused_ok = ^{mem_address, addr_q[0]};
  mem_responder_array #(.ADDR_BITS(ADDR_BITS)) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we_i   (rst_n && commit && c_wr && !mis),
    .re_i   (rst_n && commit && c_rd),
    .zero_i (mis),
    .be_i   (c_be),
    .addr_i (c_addr[ADDR_BITS:1]),
    .wdata_i(c_wdata),
    .rdata_o(mem_rdata)
  );
  // handshake FSM: latch request in IDLE, count wait states, pulse response for one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      resp_q <= commit;
      busy_q <= idle ? req : state_q == WAIT;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
      err_q  <= commit && mis;
`endif
      if (idle && req) begin
        addr_q  <= mem_address[ADDR_BITS:0];
        wdata_q <= mem_wdata;
        be_q    <= mem_byte_enable;
        wr_q    <= mem_write;
        rd_q    <= mem_read;
        state_q <= WAIT_STATES == 0 ? RESP : WAIT;
        cnt_q   <= 4'(WAIT_STATES);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_q <= RESP;
      end else if (state_q == RESP) begin
        state_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized scoreboard bench for mem_responder against an array reference model
module tb_mem_responder;
  localparam int WS = 2;
  logic        clk = 0, rst_n = 0;
  logic [15:0] mem_address = 0, mem_wdata = 0, mem_rdata;
  logic        mem_read = 0, mem_write = 0, mem_resp, busy;
  logic [1:0]  mem_byte_enable = 0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  logic        mem_error;
`endif
  int compared = 0, mismatched = 0, resp_seen = 0;
  typedef struct {logic [15:0] rd; bit err;} exp_t;
  exp_t        sb[$];
  logic [15:0] model [256];
  logic [15:0] model_rdata = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp), .busy(busy)
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    , .mem_error(mem_error)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every response pops the oldest expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (mem_resp) begin
      resp_seen++;
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_resp: got response with empty scoreboard, rdata %0h", mem_rdata);
      end else begin
        e = sb.pop_front();
        check("rdata", mem_rdata, e.rd);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        check("mem_error", mem_error, e.err);
`endif
      end
    end
  end

  task automatic do_txn(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd);
    int n;
    logic [7:0] idx;
    logic [15:0] old;
    bit mis;
    exp_t e;
    idx = a[8:1];
    old = model[idx];
    mis = 0;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    mis = (be == 2'b11) && a[0];
`endif
    if (wr && !mis) model[idx] = {be[1] ? wd[15:8] : old[15:8], be[0] ? wd[7:0] : old[7:0]};
    if (rd) model_rdata = mis ? 16'h0 : model[idx];
    e.rd = model_rdata;
    e.err = mis;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!mem_resp) begin
        mem_address = 16'($urandom); mem_wdata = 16'($urandom); mem_byte_enable = 2'($urandom);
      end
    end while (!mem_resp && n < 50);
    check("latency", n, WS + 1);
    check("busy_in_resp", busy, 1);
    mem_read = 0; mem_write = 0;
  endtask

  initial begin
    int s;
    bit rd, wr;
    int op;
    repeat (2) @(negedge clk);
    rst_n = 1;
    check("reset_resp", mem_resp, 0);
    check("reset_rdata", mem_rdata, 0);
    check("reset_busy", busy, 0);
    do_txn(0, 1, 16'h0010, 2'b11, 16'hBEEF);
    do_txn(1, 0, 16'h0010, 2'b11, 16'h0000);
    do_txn(0, 1, 16'h0020, 2'b11, 16'h1234);
    do_txn(0, 1, 16'h0020, 2'b10, 16'hAB00);
    do_txn(1, 0, 16'h0020, 2'b11, 16'h0000);
    do_txn(0, 1, 16'h0202, 2'b11, 16'h5555);
    do_txn(1, 0, 16'h0002, 2'b11, 16'h0000);
    do_txn(0, 1, 16'h0010, 2'b00, 16'h1111);
    do_txn(1, 0, 16'h0010, 2'b11, 16'h0000);
    do_txn(1, 1, 16'h0040, 2'b01, 16'h00CD);
    do_txn(0, 1, 16'h0030, 2'b11, 16'h0001);
    @(negedge clk);
    mem_write = 1; mem_address = 16'h0030; mem_byte_enable = 2'b11; mem_wdata = 16'hFFFF;
    @(negedge clk);
    s = resp_seen;
    rst_n = 0; mem_write = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_rdata = 0;
    repeat (3) @(negedge clk);
    check("no_resp_after_abort", resp_seen - s, 0);
    check("rdata_after_reset", mem_rdata, 0);
    check("busy_after_reset", busy, 0);
    do_txn(1, 0, 16'h0030, 2'b11, 16'h0000);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    do_txn(1, 0, 16'h0011, 2'b11, 16'h0000);
    do_txn(1, 0, 16'h0010, 2'b11, 16'h0000);
    do_txn(0, 1, 16'h0021, 2'b11, 16'h7777);
    do_txn(1, 0, 16'h0020, 2'b11, 16'h0000);
`endif
    for (int i = 0; i < 256; i++) do_txn(0, 1, {7'd0, 8'(i), 1'b0}, 2'b11, 16'($urandom));
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 2);
      rd = op != 1;
      wr = op != 0;
      do_txn(rd, wr, 16'($urandom), 2'($urandom), 16'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
